// File: rtl/full_adder4_pkg.sv
// Shared constants and a behavioural golden adder for the full_adder4 block.
package full_adder4_pkg;

  // Delivered operand/sum width.
  localparam int WIDTH_DEFAULT = 4;

  // Largest supported operand width; sizes the golden-model arguments.
  localparam int WIDTH_MAX = 32;

  // Golden sum: {carry, sum} = a + b + cin as a (WIDTH_MAX+1)-bit unsigned value.
  // Callers pass zero-extended operands and keep the low WIDTH+1 bits,
  // whose top bit is then the carry-out of a WIDTH-bit add.
  function automatic logic [WIDTH_MAX:0] ref_add(
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b,
    input logic                 cin
  );
    return (WIDTH_MAX+1)'(a) + (WIDTH_MAX+1)'(b) + (WIDTH_MAX+1)'(cin);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full-adder cell; the ripple link of full_adder4.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder4.sv
// Registered ripple-carry adder: {cout4, s} = a + b + cin, one cycle latency.
// Optional signed-overflow output ovf is enabled by defining FULL_ADDER4_OVF_EN.
module full_adder4
  import full_adder4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout4,
  output logic             out_valid
`ifdef FULL_ADDER4_OVF_EN
  ,
  output logic             ovf
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_cell u_cell (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (sum_comb[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Capture a new result only when operands are valid; otherwise hold, so
  // unknown operands under in_valid=0 never reach the registers.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum_comb;
      cout_d = carry[WIDTH];
    end
  end

  // Output registers; reset clears them immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign cout4     = cout_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER4_OVF_EN
  logic ovf_q, ovf_d;

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  // Overflow flag register, same timing and reset as the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder4.sv
// Directed-vector bench for full_adder4 with hand-computed expected results.
module tb_full_adder4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout4;
  logic       out_valid;
`ifdef FULL_ADDER4_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;

  full_adder4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout4     (cout4),
    .out_valid (out_valid)
`ifdef FULL_ADDER4_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Drive one set of operands, let one rising edge capture them, sample 1 time unit later.
  task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic vv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  // Check sum, carry-out and valid in one go.
  task automatic check_out(input string tag, input logic [3:0] es, input logic ec, input logic ev);
    check_val({tag, ".s"},         32'(s),         32'(es));
    check_val({tag, ".cout4"},     32'(cout4),     32'(ec));
    check_val({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    cin      = 1'b0;
    #2;
    check_out("reset_async", 4'h0, 1'b0, 1'b0);
    // Valid operands while reset is held must not be captured.
    apply(4'b0101, 4'b0101, 1'b1, 1'b1);
    check_out("reset_hold", 4'h0, 1'b0, 1'b0);
`ifdef FULL_ADDER4_OVF_EN
    check_val("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    // First capture after release.
    apply(4'b0001, 4'b0001, 1'b0, 1'b1);
    check_out("first_1p1", 4'b0010, 1'b0, 1'b1);

    // Back-to-back vectors, one per cycle.
    apply(4'b0011, 4'b0001, 1'b0, 1'b1);
    check_out("b2b_3p1", 4'b0100, 1'b0, 1'b1);
    apply(4'b0001, 4'b0111, 1'b0, 1'b1);
    check_out("b2b_1p7", 4'b1000, 1'b0, 1'b1);
    apply(4'b1000, 4'b0111, 1'b0, 1'b1);
    check_out("b2b_8p7", 4'b1111, 1'b0, 1'b1);
    apply(4'b1000, 4'b1111, 1'b0, 1'b1);
    check_out("b2b_8pF", 4'b0111, 1'b1, 1'b1);

    // Carry-in boundaries.
    apply(4'b1111, 4'b1111, 1'b1, 1'b1);
    check_out("cin_FpFp1", 4'b1111, 1'b1, 1'b1);
    apply(4'b0000, 4'b0000, 1'b1, 1'b1);
    check_out("cin_0p0p1", 4'b0001, 1'b0, 1'b1);
    apply(4'b0000, 4'b0000, 1'b0, 1'b1);
    check_out("zero_0p0", 4'b0000, 1'b0, 1'b1);

    // Hold with unknown operands while in_valid is low.
    apply(4'b0011, 4'b0001, 1'b0, 1'b1);
    check_out("pre_hold", 4'b0100, 1'b0, 1'b1);
    apply(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
    check_out("hold1", 4'b0100, 1'b0, 1'b0);
    apply(4'b1111, 4'b1111, 1'b1, 1'b0);
    check_out("hold2", 4'b0100, 1'b0, 1'b0);

    // Asynchronous reset between edges while a result is valid.
    apply(4'b1000, 4'b1111, 1'b0, 1'b1);
    check_out("pre_rst", 4'b0111, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_out("mid_rst", 4'h0, 1'b0, 1'b0);
    apply(4'b0010, 4'b0010, 1'b0, 1'b1);
    check_out("mid_rst_hold", 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    apply(4'b0010, 4'b0011, 1'b0, 1'b1);
    check_out("post_rst", 4'b0101, 1'b0, 1'b1);

`ifdef FULL_ADDER4_OVF_EN
    apply(4'b0111, 4'b0001, 1'b0, 1'b1);
    check_out("ovf_7p1", 4'b1000, 1'b0, 1'b1);
    check_val("ovf_7p1.ovf", 32'(ovf), 32'd1);
    apply(4'b1000, 4'b1111, 1'b0, 1'b1);
    check_out("ovf_8pF", 4'b0111, 1'b1, 1'b1);
    check_val("ovf_8pF.ovf", 32'(ovf), 32'd1);
    apply(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
    check_val("ovf_hold.ovf", 32'(ovf), 32'd1);
    apply(4'b0001, 4'b0001, 1'b0, 1'b1);
    check_out("ovf_1p1", 4'b0010, 1'b0, 1'b1);
    check_val("ovf_1p1.ovf", 32'(ovf), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time guard so the bench can never hang.
  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
